traffic_light_monitor: RTL
==========================

# traffic_light_monitor

Passive checker that sits on the `light[2:0]` output of the traffic light controller and consumes it as the receiving end of that interface. It decodes the one-hot light code into a phase, measures how many cycles each phase lasts, and checks legality, ordering and per-phase duration limits. It also counts completed signal cycles. It drives no traffic outputs. It is instantiated beside the controller in benches and in the top level as a runtime safety monitor.

## Interface
Parameters:
- `CNT_W`, 8: width of the dwell counter; it saturates at 2^CNT_W-1.
- `RED_MIN`, 1: minimum legal red dwell in cycles.
- `RED_MAX`, 200: maximum legal red dwell in cycles.
- `GRN_MIN`, 1: minimum legal green dwell in cycles.
- `GRN_MAX`, 200: maximum legal green dwell in cycles.
- `YEL_MIN`, 1: minimum legal yellow dwell in cycles.
- `YEL_MAX`, 200: maximum legal yellow dwell in cycles.

Ports:
- `clk`  in  1  single clock; all state is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `light`  in  3  observed light: bit2 red, bit1 yellow, bit0 green.
- `clear`  in  1  synchronous clear of the sticky error flags and `cycles_done`.
- `phase`  out  2  current phase: 0 UNKNOWN, 1 RED, 2 GREEN, 3 YELLOW.
- `dwell`  out  CNT_W  cycles spent in the current phase, counting the entry cycle.
- `cycles_done`  out  16  completed legal YELLOW→RED transitions; wraps modulo 2^16.
- `err_illegal`  out  1  sticky; set when `light` is not one-hot (000, 011, 111, ...).
- `err_order`  out  1  sticky; set on an illegal phase transition.
- `err_time`  out  1  sticky; set on a dwell outside [MIN, MAX].
- `err_pulse`  out  1  one-cycle pulse on every new error event, whether or not the flag was already set.

## Operation
- Reset: `phase`=UNKNOWN. `dwell`, `cycles_done`, all `err_*` and the internal `partial` flag are 0.
- `light` is sampled every rising edge. All outputs are registered.
- UNKNOWN plus a legal one-hot code: enter the decoded phase, `dwell`=1, `partial`=1. No order check is made.
- Any phase plus a non-one-hot code: `phase`=UNKNOWN, `dwell`=0, set `err_illegal`, pulse `err_pulse`.
- Same code as the current phase: `dwell` += 1, saturating.
- Legal transitions: RED→GREEN, GREEN→YELLOW, YELLOW→RED. Each enters the new phase with `dwell`=1, `partial`=0.
  - YELLOW→RED also increments `cycles_done`.
- Illegal transitions: RED→YELLOW, GREEN→RED, YELLOW→GREEN.
  - Set `err_order` and pulse `err_pulse`.
  - Adopt the new phase with `dwell`=1, `partial`=1.
  - No MIN check is made on the phase being exited.
- MIN check:
  - Applies on a legal exit, and only when `partial`=0.
  - Error if the exiting phase's final `dwell` < its MIN.
  - On error, set `err_time` and pulse `err_pulse`.
- MAX check:
  - Applies while the phase is unchanged. The error fires on the edge where `dwell` would become MAX+1.
  - Fires once per phase visit.
  - Applies even when `partial`=1.
- `clear`:
  - Zeroes `err_illegal`, `err_order`, `err_time` and `cycles_done`.
  - Does not affect `phase`, `dwell` or `partial`.
  - If an error event occurs on the same edge, that flag ends up set: the new error wins.
  - If a YELLOW→RED transition occurs on the same edge, `cycles_done` ends up 1.

## Timing
- Latency: one cycle from a `light` change to the updated `phase`, `dwell` and error outputs.
- `err_pulse` is high for exactly the cycle after the offending sample. It is not stretched across consecutive errors; back-to-back errors keep it high on each cycle.
- Asserting `reset` asynchronously forces the reset values at any point, mid-phase included. After release, monitoring starts in UNKNOWN.
- Dwell saturation: `dwell` stops at 2^CNT_W-1. MAX ≤ 2^CNT_W-2 is required so that a MAX violation is always detectable.

## Structure
- Shared package `traffic_pkg` holds:
  - light encodings: `LIGHT_RED`=3'b100, `LIGHT_YEL`=3'b010, `LIGHT_GRN`=3'b001;
  - the phase enum (UNKNOWN/RED/GREEN/YELLOW), used by both the controller and this monitor.
- One sub-module, `tl_dwell_counter`: a saturating CNT_W counter with load-to-1, clear-to-0 and an `at_limit(max)` compare output.

## Test plan
Bench parameters throughout: RED_MIN=3, RED_MAX=6, GRN_MIN=2, GRN_MAX=5, YEL_MIN=1, YEL_MAX=2. Error flags are sticky, so each scenario starts from `reset`.
- Reset with `light`=100 held → the cycle after release: `phase`=1, `dwell`=1, all errors 0. After 4 more cycles: `dwell`=5.
- Legal loop: red 4, green 3, yellow 2, red ... → no errors. `cycles_done`=1 after the first YELLOW→RED, 2 after the second.
- Post-sync loop with green held for only 1 cycle → the exit to yellow sets `err_time` with a single `err_pulse`. A subsequent red of 7 cycles → the MAX check fires on the 7th cycle of red.
- `light`=011 mid-green → `err_illegal`=1, `phase`=0, `dwell`=0. Then 001 → `phase`=2, no order error.
- Post-sync loop, then RED→YELLOW directly → `err_order`=1 and `cycles_done` unchanged. The next yellow→red increments `cycles_done`, but no MIN error is flagged for the partial yellow.
- `clear` on the same edge as a GREEN→RED sample → `err_order`=1 afterwards and `cycles_done`=0. Then `reset` asserted mid-phase → all outputs 0 immediately.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared light encodings and phase type for the traffic light controller and monitor.
package traffic_pkg;

    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

    typedef enum logic [1:0] {
        PH_UNKNOWN = 2'd0,
        PH_RED     = 2'd1,
        PH_GREEN   = 2'd2,
        PH_YELLOW  = 2'd3
    } phase_t;

    // Anything that is not exactly one lamp lit decodes to UNKNOWN.
    function automatic phase_t decode_light(input logic [2:0] light);
        case (light)
            LIGHT_RED: return PH_RED;
            LIGHT_GRN: return PH_GREEN;
            LIGHT_YEL: return PH_YELLOW;
            default:   return PH_UNKNOWN;
        endcase
    endfunction

    // The only phase a given phase may legally hand over to.
    function automatic phase_t legal_successor(input phase_t ph);
        case (ph)
            PH_RED:    return PH_GREEN;
            PH_GREEN:  return PH_YELLOW;
            PH_YELLOW: return PH_RED;
            default:   return PH_UNKNOWN;
        endcase
    endfunction

endpackage

// File: rtl/tl_dwell_counter.sv
// Saturating dwell counter: clear-to-0, load-to-1, increment, and equality compare against a limit.
module tl_dwell_counter
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] max_i,
    output logic [CNT_W-1:0] count_o,
    output logic             at_limit_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear beats load beats increment; increment stops at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = CNT_W'(1);
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o    = count_q;
    assign at_limit_o = (count_q == max_i);

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive runtime checker for the traffic light output: phase tracking, dwell timing, order and legality.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned RED_MIN = 1,
    parameter int unsigned RED_MAX = 200,
    parameter int unsigned GRN_MIN = 1,
    parameter int unsigned GRN_MAX = 200,
    parameter int unsigned YEL_MIN = 1,
    parameter int unsigned YEL_MAX = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       light,
    input  logic             clear,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] dwell,
    output logic [15:0]      cycles_done,
    output logic             err_illegal,
    output logic             err_order,
    output logic             err_time,
    output logic             err_pulse
);

    phase_t      phase_q, phase_d;
    logic        partial_q, partial_d;
    logic [15:0] cycles_q, cycles_d;
    logic        ill_q, ill_d;
    logic        ord_q, ord_d;
    logic        tim_q, tim_d;
    logic        pulse_q, pulse_d;

    phase_t           obs;
    logic             cnt_clr, cnt_load, cnt_inc, at_limit;
    logic [CNT_W-1:0] dwell_cnt, min_sel, max_sel;
    logic             ev_illegal, ev_order, ev_time, cyc_inc;

    // Per-phase limits for the phase currently being tracked.
    always_comb begin
        min_sel = '0;
        max_sel = '1;
        case (phase_q)
            PH_RED:    begin min_sel = CNT_W'(RED_MIN); max_sel = CNT_W'(RED_MAX); end
            PH_GREEN:  begin min_sel = CNT_W'(GRN_MIN); max_sel = CNT_W'(GRN_MAX); end
            PH_YELLOW: begin min_sel = CNT_W'(YEL_MIN); max_sel = CNT_W'(YEL_MAX); end
            default:   ;
        endcase
    end

    tl_dwell_counter #(.CNT_W(CNT_W)) u_dwell (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .inc_i      (cnt_inc),
        .max_i      (max_sel),
        .count_o    (dwell_cnt),
        .at_limit_o (at_limit)
    );

    // Phase tracking and error event detection for the current light sample.
    always_comb begin
        phase_d    = phase_q;
        partial_d  = partial_q;
        cnt_clr    = 1'b0;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;
        ev_illegal = 1'b0;
        ev_order   = 1'b0;
        ev_time    = 1'b0;
        cyc_inc    = 1'b0;
        obs        = decode_light(light);

        if (obs == PH_UNKNOWN) begin
            phase_d    = PH_UNKNOWN;
            cnt_clr    = 1'b1;
            ev_illegal = 1'b1;
        end else if (phase_q == PH_UNKNOWN) begin
            phase_d   = obs;
            cnt_load  = 1'b1;
            partial_d = 1'b1;
        end else if (obs == phase_q) begin
            cnt_inc = 1'b1;
            // Equality with MAX means this sample pushes dwell to MAX+1; fires once per visit.
            ev_time = at_limit;
        end else if (obs == legal_successor(phase_q)) begin
            phase_d   = obs;
            cnt_load  = 1'b1;
            partial_d = 1'b0;
            ev_time   = !partial_q && (dwell_cnt < min_sel);
            cyc_inc   = (phase_q == PH_YELLOW);
        end else begin
            phase_d   = obs;
            cnt_load  = 1'b1;
            partial_d = 1'b1;
            ev_order  = 1'b1;
        end

        // Clear first, then OR in same-edge events so a new error survives a clear.
        ill_d    = (clear ? 1'b0 : ill_q) | ev_illegal;
        ord_d    = (clear ? 1'b0 : ord_q) | ev_order;
        tim_d    = (clear ? 1'b0 : tim_q) | ev_time;
        cycles_d = (clear ? 16'd0 : cycles_q) + {15'd0, cyc_inc};
        pulse_d  = ev_illegal | ev_order | ev_time;
    end

    // Monitor state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q   <= PH_UNKNOWN;
            partial_q <= 1'b0;
            cycles_q  <= '0;
            ill_q     <= 1'b0;
            ord_q     <= 1'b0;
            tim_q     <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            partial_q <= partial_d;
            cycles_q  <= cycles_d;
            ill_q     <= ill_d;
            ord_q     <= ord_d;
            tim_q     <= tim_d;
            pulse_q   <= pulse_d;
        end
    end

    assign phase       = phase_q;
    assign dwell       = dwell_cnt;
    assign cycles_done = cycles_q;
    assign err_illegal = ill_q;
    assign err_order   = ord_q;
    assign err_time    = tim_q;
    assign err_pulse   = pulse_q;

endmodule
